// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) that retires one quotient bit per cycle.
// Optional macro DIV_FAST_ZERO_EN lets trivial cases (zero divisor or small dividend) skip the iteration.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  div_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  // Operand magnitudes and result signs for the accepting cycle.
  logic             a_neg, b_neg, div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg    = is_signed & dividend[WIDTH-1];
  assign b_neg    = is_signed & divisor[WIDTH-1];
  assign a_mag    = a_neg ? -dividend : dividend;
  assign b_mag    = b_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;
  logic             fits;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] rem_lo;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign shifted  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, dvs_q};
  assign fits     = ~diff[WIDTH+1];
  assign rem_next = fits ? diff[WIDTH:0] : shifted;
  assign quo_next = {quo_q[WIDTH-2:0], fits};
  assign rem_lo   = rem_next[WIDTH-1:0];
  assign q_fix    = neg_quo_q ? -quo_next : quo_next;
  assign r_fix    = neg_rem_q ? -rem_lo : rem_lo;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            // A zero divisor yields all ones unsigned, so its quotient is never negated.
            neg_quo_d = (a_neg ^ b_neg) & ~div_zero;
            neg_rem_d = a_neg;
            count_d   = '0;
`ifdef DIV_FAST_ZERO_EN
            if (div_zero || (a_mag < b_mag)) begin
              state_d     = DONE;
              quotient_d  = div_zero ? '1 : '0;
              remainder_d = dividend;
            end else begin
              state_d = CALC;
            end
`else
            state_d = CALC;
`endif
          end
        end
        CALC: begin
          rem_d   = rem_next;
          quo_d   = quo_next;
          count_d = count_q + CW'(1);
          if (count_q == LAST_STEP) begin
            state_d     = DONE;
            quotient_d  = q_fix;
            remainder_d = r_fix;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign busy      = ((state_q == IDLE) & start & ~flush) | (state_q == CALC);
  assign done      = (state_q == DONE) & ~flush;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed vectors, flush and mid-operation reset.
module tb_div_unit;

  localparam int WIDTH = 32;

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  div_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] prev_q = '0;
  logic [31:0] prev_r = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (time %0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? -v : v;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one divide, check the busy window, and wait for its result to retire.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    int n;
    int lat;
    int busy_cnt;
    exp_t e;
    lat = WIDTH + 1;
`ifdef DIV_FAST_ZERO_EN
    if (b == 32'd0 || mag(a, s) < mag(b, s)) lat = 1;
`endif
    is_signed = s;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    n         = cyc;
    e.q = eq; e.r = er; e.cyc = n + lat;
    sb.push_back(e);
    @(negedge clk);
    check("busy_accept", {31'b0, busy}, 32'd1);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 32'h0000_0003;
    busy_cnt = 1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
      @(posedge clk);
    end
    check("busy_cycles", busy_cnt, lat);
    @(posedge clk);
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    check("result_retired", sb.size(), 32'd0);
    prev_q = eq;
    prev_r = er;
    #1;
  endtask

  initial begin
    int n;
    resetn    = 1'b0;
    flush     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #3;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

    issue(1'b0, 32'd100,       32'd7,         32'd14,        32'd2);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    issue(1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678);
    issue(1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9);
    issue(1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0);
    issue(1'b0, 32'd3,         32'd10,        32'd0,         32'd3);
    issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE);
    issue(1'b0, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 32'hF);

    // Flush outranks start in IDLE: nothing is accepted.
    is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_prio_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_prio_idle", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1;

    // Flush in cycle 10 of DIVU 1000/3.
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    n = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < n + 10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_quotient", quotient, prev_q);
    check("flush_remainder", remainder, prev_r);
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, 32'd5, 32'd5, 32'd1, 32'd0);
    issue(1'b0, 32'd17, 32'd5, 32'd3, 32'd2);

    // Reset in cycle 5 of CALC.
    dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    n = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < n + 5) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_quotient", quotient, 32'd0);
    check("midrst_remainder", remainder, 32'd0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (45) @(posedge clk);
    #1;
    check("post_rst_busy", {31'b0, busy}, 32'd0);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port flush  input  1  cancel any in-flight divide (exception/branch flush from the pipeline).
REQ-005 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-006 SHALL have port is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
REQ-007 SHALL have ports dividend, divisor  input  WIDTH  operands, sampled in the accepting cycle only.
REQ-008 SHALL have port busy  output  1  stall request into the pipeline stage registers.
REQ-009 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-010 SHALL have ports quotient, remainder  output  WIDTH  results, LO and HI respectively, registered.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, DONE.
REQ-012 SHALL accept a request in IDLE when start=1 and flush=0, latch operand magnitudes and result signs, and enter CALC.
REQ-013 SHALL drive busy combinationally: busy = (IDLE & start & ~flush) | CALC; busy=0 in DONE.
REQ-014 SHALL perform restoring division, one quotient bit per cycle, exactly WIDTH cycles in CALC, using a WIDTH+1-bit partial remainder.
REQ-015 SHALL, with start accepted in cycle N, hold busy high in cycles N..N+WIDTH and assert done only in cycle N+WIDTH+1 (DONE), then return to IDLE.
REQ-016 SHALL update quotient/remainder on entry to DONE and hold them stable until the next DONE or reset.
REQ-017 SHALL ignore start while in CALC or DONE; back-to-back requests are accepted from the cycle after DONE.
REQ-018 SHALL, for signed ops, negate quotient iff operand signs differ, and give remainder the dividend's sign.
REQ-019 SHALL return quotient=0x80000000, remainder=0 for signed 0x80000000 / 0xFFFFFFFF (WIDTH=32); no trap.
REQ-020 SHALL return quotient=all ones, remainder=dividend for divisor=0, regardless of is_signed.
REQ-021 SHALL, on flush in any state, go to IDLE next cycle, suppress done, and leave quotient/remainder unchanged; flush takes priority over start.

Reset
REQ-022 SHALL, while resetn=0, force state IDLE and clear busy, done, quotient, remainder and all internal registers to 0, independent of clk.
REQ-023 SHALL, on reset mid-CALC, discard the operation; no done after release.

Configuration
REQ-024 SHALL support macro DIV_FAST_ZERO_EN.
REQ-025 SHALL, with DIV_FAST_ZERO_EN defined, go IDLE->DONE directly when divisor=0 or |dividend| < |divisor| (unsigned magnitude compare), giving done in cycle N+1 with busy high only in cycle N; results per REQ-018/REQ-020 (quotient 0, remainder = dividend for the small-dividend case).
REQ-026 SHALL, without DIV_FAST_ZERO_EN, always take the full WIDTH-cycle CALC path; results are identical in both builds.

Structure
REQ-027 SHALL place typedef div_state_t (IDLE, CALC, DONE) and constant DIV_WIDTH=32 in shared package div_pkg.
REQ-028 SHALL be a single module; no sub-module; iteration step, sign fix-up and FSM are inline.

Verification
REQ-029 DIVU 100/7 at cycle 0 -> busy 1 in cycles 0..32, done in cycle 33, quotient=14, remainder=2.
REQ-030 DIV 0xFFFFFFF9 (-7) / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-032 DIVU 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678; done in cycle 33, or cycle 1 with DIV_FAST_ZERO_EN.
REQ-033 flush in cycle 10 of DIVU 1000/3 -> IDLE in cycle 11, busy 0, no done, outputs unchanged; then DIVU 5/5 -> quotient=1, remainder=0.
REQ-034 resetn low in cycle 5 of CALC -> busy, done, quotient, remainder = 0 immediately; no done after release.
